lb_reg_bank: RTL and testbench

Generic register bank that terminates the local bus (waddr/wdata/wen/wstrb/wready, raddr/ren/rdata/rvalid) driven by any *2lb bridge (APB, AXI-Lite, Avalon-MM, Wishbone or SPI).
- Provides NUM_REGS read/write control registers with byte-strobe writes and per-register write pulses.
- Provides NUM_REGS read-only status words, snapshotted at read acceptance.
- Read latency is configurable.
- Sits directly downstream of the bridge, in place of a generated register map.

---
 rtl/lb_pkg.sv | 64 ++++++
 rtl/lb_rd_resp.sv | 71 +++++++
 rtl/lb_reg_bank.sv | 107 ++++++++++
 tb/tb_lb_reg_bank.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_pkg.sv
// Shared types and the address decoder for the local-bus register bank.
package lb_pkg;

  localparam int unsigned LB_AW_MAX = 64;
  localparam int unsigned LB_IDX_W  = 7;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    DRAIN
  } lb_rd_state_e;

  typedef enum logic [1:0] {
    DEC_RW,
    DEC_RO,
    DEC_NONE
  } lb_dec_kind_e;

  typedef struct packed {
    lb_dec_kind_e          kind;
    logic [LB_IDX_W-1:0]   idx;
  } lb_dec_t;

  // Byte address -> register window. Offset wraps at addr_w bits so addresses
  // below the base land far above the mapped range.
  function automatic lb_dec_t lb_decode(
    input logic [LB_AW_MAX-1:0] addr,
    input logic [LB_AW_MAX-1:0] base,
    input int unsigned          num_regs,
    input int unsigned          strb_w,
    input int unsigned          addr_w
  );
    logic [LB_AW_MAX-1:0] mask;
    logic [LB_AW_MAX-1:0] off;
    logic [LB_AW_MAX-1:0] word;
    logic [LB_AW_MAX-1:0] ro_word;
    int                   shift;
    lb_dec_t              res;

    mask = (addr_w >= LB_AW_MAX) ? '1 : ((LB_AW_MAX'(1) << addr_w) - LB_AW_MAX'(1));
    off  = (addr - base) & mask;

    shift = 0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) < strb_w) shift = i + 1;
    end

    word    = off >> shift;
    ro_word = word - LB_AW_MAX'(num_regs);

    res.kind = DEC_NONE;
    res.idx  = '0;
    if (word < LB_AW_MAX'(num_regs)) begin
      res.kind = DEC_RW;
      res.idx  = word[LB_IDX_W-1:0];
    end else if (word < LB_AW_MAX'(2 * num_regs)) begin
      res.kind = DEC_RO;
      res.idx  = ro_word[LB_IDX_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/lb_rd_resp.sv
// Read response engine: snapshots read data at acceptance, delays it by
// READ_LATENCY cycles, emits a one-cycle rvalid, then waits for ren to drop.
module lb_rd_resp
  import lb_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ren,
  input  logic [DATA_W-1:0] rd_word,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  localparam int unsigned CNT_W = 2;

  lb_rd_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;

  // NOTE: every output and next-state value gets a default first so no
  // branch leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rvalid  = 1'b0;
    rdata   = '0;

    case (state_q)
      IDLE: begin
        if (ren) begin
          data_d  = rd_word;
          cnt_d   = CNT_W'(READ_LATENCY - 1);
          state_d = (READ_LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        rvalid  = 1'b1;
        rdata   = data_q;
        state_d = DRAIN;
      end
      DRAIN: begin
        // ren still high belongs to the request just answered.
        if (!ren) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments in clocked blocks so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/lb_reg_bank.sv
// Local-bus register bank: NUM_REGS byte-strobed RW registers with write
// pulses, NUM_REGS read-only status words, and a fixed-latency read path.
module lb_reg_bank
  import lb_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       NUM_REGS     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int unsigned       READ_LATENCY = 1,
  parameter logic [DATA_W-1:0] RESET_VAL    = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       wen,
  input  logic [DATA_W/8-1:0]        wstrb,
  output logic                       wready,
  input  logic [ADDR_W-1:0]          raddr,
  input  logic                       ren,
  output logic [DATA_W-1:0]          rdata,
  output logic                       rvalid,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        reg_wpulse,
  input  logic [NUM_REGS*DATA_W-1:0] status_in
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wpulse_q, wpulse_d;
  logic                wready_q, wready_d;
  logic                wr_accept;
  lb_dec_t             wr_dec;
  lb_dec_t             rd_dec;
  logic [DATA_W-1:0]   rd_word;

  assign wr_dec = lb_decode(LB_AW_MAX'(waddr), LB_AW_MAX'(BASE_ADDR),
                            NUM_REGS, STRB_W, ADDR_W);
  assign rd_dec = lb_decode(LB_AW_MAX'(raddr), LB_AW_MAX'(BASE_ADDR),
                            NUM_REGS, STRB_W, ADDR_W);

  assign wr_accept = wen && wready_q;

  // Any accepted write, mapped or not, costs one dead cycle on wready.
  always_comb begin
    regs_d   = regs_q;
    wpulse_d = '0;
    wready_d = !wr_accept;
    if (wr_accept && wr_dec.kind == DEC_RW) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_dec.idx == LB_IDX_W'(i)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wstrb[b]) regs_d[i][b*8 +: 8] = wdata[b*8 +: 8];
          end
          wpulse_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wready_q <= 1'b0;
      wpulse_q <= '0;
      // NOTE: this array is a set of control flops, not a RAM, so every word
      // is reset; a true storage memory would be left without reset.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      wready_q <= wready_d;
      wpulse_q <= wpulse_d;
      regs_q   <= regs_d;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_dec.idx == LB_IDX_W'(i)) begin
        if (rd_dec.kind == DEC_RW) rd_word = regs_q[i];
        if (rd_dec.kind == DEC_RO) rd_word = status_in[i*DATA_W +: DATA_W];
      end
    end
  end

  lb_rd_resp #(
    .DATA_W      (DATA_W),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_resp (
    .clk    (clk),
    .rst    (rst),
    .ren    (ren),
    .rd_word(rd_word),
    .rdata  (rdata),
    .rvalid (rvalid)
  );

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gen_reg_out
    assign reg_q[gi*DATA_W +: DATA_W] = regs_q[gi];
  end

  assign wready     = wready_q;
  assign reg_wpulse = wpulse_q;

endmodule

// File: tb/tb_lb_reg_bank.sv
// Three banks (read latency 1, 3, 4) on shared bus inputs, checked against a
// transaction-level model of registers and status words.
module tb_lb_reg_bank;

  localparam int          NI        = 3;
  localparam logic [31:0] RESET_VAL = 32'h5a5a_0f0f;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  waddr, wdata, raddr;
  logic         wen, ren;
  logic [3:0]   wstrb;
  logic [127:0] status_in;

  logic         wready_o [NI];
  logic [31:0]  rdata_o  [NI];
  logic         rvalid_o [NI];
  logic [127:0] regq_o   [NI];
  logic [3:0]   wpulse_o [NI];

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_reg  [4];
  logic [31:0] m_stat [4];

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    lb_reg_bank #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .NUM_REGS    (4),
      .BASE_ADDR   (32'h0),
      .READ_LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4)),
      .RESET_VAL   (RESET_VAL)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .waddr     (waddr),
      .wdata     (wdata),
      .wen       (wen),
      .wstrb     (wstrb),
      .wready    (wready_o[g]),
      .raddr     (raddr),
      .ren       (ren),
      .rdata     (rdata_o[g]),
      .rvalid    (rvalid_o[g]),
      .reg_q     (regq_o[g]),
      .reg_wpulse(wpulse_o[g]),
      .status_in (status_in)
    );
  end

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned word_of(input logic [31:0] a);
    return (a - 32'h0) >> 2;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    int unsigned w;
    w = word_of(a);
    if (w < 4) return m_reg[w];
    if (w < 8) return m_stat[w-4];
    return 32'h0;
  endfunction

  function automatic logic [3:0] exp_pulse(input logic [31:0] a);
    int unsigned w;
    w = word_of(a);
    return (w < 4) ? 4'(1 << w) : 4'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned w;
    w = word_of(a);
    if (w < 4) begin
      for (int b = 0; b < 4; b++) if (s[b]) m_reg[w][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  task automatic set_status(input int i, input logic [31:0] v);
    m_stat[i] = v;
    status_in[i*32 +: 32] = v;
  endtask

  task automatic check_regs(input string tag);
    for (int g = 0; g < NI; g++)
      for (int i = 0; i < 4; i++)
        check($sformatf("%s_L%0d_r%0d", tag, lat_of(g), i), regq_o[g][i*32 +: 32], m_reg[i]);
  endtask

  task automatic check_wr_side(input string tag, input logic rdy, input logic [3:0] pulse);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("%s_wready_L%0d", tag, lat_of(g)), wready_o[g], rdy);
      check($sformatf("%s_pulse_L%0d", tag, lat_of(g)), wpulse_o[g], pulse);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    waddr = a; wdata = d; wstrb = s; wen = 1'b1;
    n = 0;
    while (wready_o[0] !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    check("wr_ready_wait", wready_o[0], 1'b1);
    tick();
    wen = 1'b0;
    model_write(a, d, s);
    check_wr_side("wr_acc", 1'b0, exp_pulse(a));
    check_regs("wr_regs");
    tick();
    check_wr_side("wr_after", 1'b1, 4'h0);
  endtask

  // mode 0: read only; 1: write to same address in the accepting cycle;
  // 2: write to same address one cycle after acceptance.
  task automatic do_read(input logic [31:0] a, input int mode);
    logic [31:0] exp;
    int          hits [NI];
    int          at   [NI];
    logic [31:0] got  [NI];
    exp = exp_read(a);
    for (int g = 0; g < NI; g++) begin
      hits[g] = 0; at[g] = 0; got[g] = 32'h0;
    end
    raddr = a; ren = 1'b1;
    if (mode == 1) begin
      waddr = a; wdata = $urandom; wstrb = 4'hF; wen = 1'b1;
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (mode == 1 && k == 1) begin
        wen = 1'b0;
        model_write(a, wdata, wstrb);
      end
      if (mode == 2 && k == 2) begin
        wen = 1'b0;
        model_write(a, wdata, wstrb);
      end
      if (mode == 2 && k == 1) begin
        waddr = a; wdata = $urandom; wstrb = 4'($urandom_range(0, 15)); wen = 1'b1;
      end
      for (int g = 0; g < NI; g++) begin
        if (rvalid_o[g] === 1'b1) begin
          hits[g]++;
          at[g]  = k;
          got[g] = rdata_o[g];
        end else begin
          check($sformatf("rd_idle_data_L%0d", lat_of(g)), rdata_o[g], 32'h0);
        end
      end
    end
    ren = 1'b0;
    for (int g = 0; g < NI; g++) begin
      check($sformatf("rd_count_L%0d", lat_of(g)), hits[g], 1);
      check($sformatf("rd_lat_L%0d", lat_of(g)), at[g], lat_of(g));
      check($sformatf("rd_data_L%0d_a%0h", lat_of(g), a), got[g], exp);
    end
    tick();
    check_regs("rd_regs");
  endtask

  initial begin
    logic [31:0] d1, d2, addr;
    rst = 1'b1; wen = 1'b0; ren = 1'b0;
    waddr = '0; wdata = '0; wstrb = '0; raddr = '0; status_in = '0;
    for (int i = 0; i < 4; i++) begin
      m_reg[i]  = RESET_VAL;
      m_stat[i] = 32'h0;
    end

    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      check($sformatf("rst_rvalid_L%0d", lat_of(g)), rvalid_o[g], 1'b0);
      check($sformatf("rst_rdata_L%0d", lat_of(g)), rdata_o[g], 32'h0);
    end
    check_wr_side("rst", 1'b0, 4'h0);
    check_regs("rst_regq");
    rst = 1'b0;
    check("rel_wready_low", wready_o[0], 1'b0);
    tick();
    check_wr_side("rel", 1'b1, 4'h0);

    do_write(32'h004, 32'hdeadbeef, 4'hF);
    check("reg1_full", regq_o[0][32 +: 32], 32'hdeadbeef);

    do_write(32'h00C, 32'h0, 4'hF);
    do_write(32'h00C, 32'hcafebabe, 4'b0110);
    check("reg3_merge", regq_o[0][96 +: 32], 32'h00feba00);

    set_status(1, 32'hc0debabe);
    do_read(32'h014, 0);
    check("status1_model", exp_read(32'h014), 32'hc0debabe);

    do_read(32'h040, 0);
    do_write(32'h010, 32'h13572468, 4'hF);
    do_read(32'h010, 0);

    // Back-to-back writes with wen held: wready 1,0,1.
    d1 = $urandom; d2 = $urandom;
    waddr = 32'h000; wdata = d1; wstrb = 4'hF; wen = 1'b1;
    check_wr_side("b2b_0", 1'b1, 4'h0);
    tick();
    model_write(32'h000, d1, 4'hF);
    waddr = 32'h008; wdata = d2;
    check_wr_side("b2b_1", 1'b0, 4'b0001);
    check_regs("b2b_1");
    tick();
    check_wr_side("b2b_2", 1'b1, 4'h0);
    check_regs("b2b_2");
    tick();
    model_write(32'h008, d2, 4'hF);
    wen = 1'b0;
    check_wr_side("b2b_3", 1'b0, 4'b0100);
    check_regs("b2b_3");
    tick();
    check_wr_side("b2b_4", 1'b1, 4'h0);

    do_read(32'h008, 1);
    do_read(32'h008, 2);
    do_read(32'h004, 2);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) set_status($urandom_range(0, 3), $urandom);
      case ($urandom_range(0, 7))
        0:       addr = 32'hFFFF_FFFC;
        default: addr = (32'($urandom_range(0, 11)) << 2) | 32'($urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 1) == 1) do_write(addr, $urandom, 4'($urandom_range(0, 15)));
      else                           do_read(addr, $urandom_range(0, 2));
    end

    // Reset in the middle of a read while the slow banks are still waiting.
    do_write(32'h000, 32'h1111_2222, 4'hF);
    raddr = 32'h004; ren = 1'b1;
    tick();
    tick();
    for (int g = 1; g < NI; g++)
      check($sformatf("pre_abort_rvalid_L%0d", lat_of(g)), rvalid_o[g], 1'b0);
    rst = 1'b1;
    waddr = 32'h004; wdata = 32'hffff_ffff; wstrb = 4'hF; wen = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) m_reg[i] = RESET_VAL;
    check_wr_side("abort", 1'b0, 4'h0);
    check_regs("abort");
    ren = 1'b0; wen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      for (int g = 0; g < NI; g++)
        check($sformatf("abort_rvalid_L%0d", lat_of(g)), rvalid_o[g], 1'b0);
    end
    rst = 1'b0;
    check("abort_rel_wready", wready_o[0], 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      for (int g = 0; g < NI; g++) begin
        check($sformatf("post_rvalid_L%0d", lat_of(g)), rvalid_o[g], 1'b0);
        check($sformatf("post_wready_L%0d", lat_of(g)), wready_o[g], 1'b1);
      end
    end
    check_regs("post_abort");
    do_read(32'h000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
